// File: rtl/spram_arbiter.sv
// spram_arbiter: two-requester arbiter in front of a single-port synchronous RAM
// with one-cycle registered, write-through read data.
// Each access walks IDLE -> ADDR -> DATA and returns to IDLE with a one-cycle
// ack to the granted requester, which also receives the RAM word in its rdata.
// Build option: define SPRAM_ARBITER_ROUND_ROBIN_EN to alternate grants on
// contention; without it requester A has fixed priority and no last-grant
// register exists.
module spram_arbiter #(
  parameter int unsigned address_width = 10,
  parameter int unsigned data_width    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  // requester A
  input  logic                     a_req,
  input  logic                     a_wr,
  input  logic [address_width-1:0] a_addr,
  input  logic [data_width-1:0]    a_wdata,
  output logic                     a_ack,
  output logic [data_width-1:0]    a_rdata,
  // requester B
  input  logic                     b_req,
  input  logic                     b_wr,
  input  logic [address_width-1:0] b_addr,
  input  logic [data_width-1:0]    b_wdata,
  output logic                     b_ack,
  output logic [data_width-1:0]    b_rdata,
  // single-port RAM
  output logic                     ram_wren,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  input  logic [data_width-1:0]    ram_q,
  // status
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;

  // Owner of the access in flight: 0 = A, 1 = B.
  logic   grant_b;

  // A requester whose ack is high is in its ack cycle and must not be
  // re-granted on the same edge; a held req becomes a new request next cycle.
  logic   a_elig;
  logic   b_elig;
  logic   pick_b;

`ifdef SPRAM_ARBITER_ROUND_ROBIN_EN
  // 1 = B was granted most recently.
  logic   last_b;
`endif

  // Eligibility and winner selection for the IDLE decision.
  always_comb begin
    a_elig = a_req && !a_ack;
    b_elig = b_req && !b_ack;
`ifdef SPRAM_ARBITER_ROUND_ROBIN_EN
    if (a_elig && b_elig) begin
      pick_b = !last_b;
    end else begin
      pick_b = b_elig;
    end
`else
    pick_b = b_elig && !a_elig;
`endif
  end

  // Access sequencer with registered RAM controls, acks, read data and busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant_b     <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      busy        <= 1'b0;
`ifdef SPRAM_ARBITER_ROUND_ROBIN_EN
      last_b      <= 1'b1;
`endif
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_elig || b_elig) begin
            state       <= ADDR;
            busy        <= 1'b1;
            grant_b     <= pick_b;
            ram_wren    <= pick_b ? b_wr    : a_wr;
            ram_address <= pick_b ? b_addr  : a_addr;
            ram_data    <= pick_b ? b_wdata : a_wdata;
`ifdef SPRAM_ARBITER_ROUND_ROBIN_EN
            last_b      <= pick_b;
`endif
          end
        end
        ADDR: begin
          // RAM samples address/data/wren on this edge; ram_q is valid in DATA.
          state    <= DATA;
          ram_wren <= 1'b0;
        end
        DATA: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (grant_b) begin
            b_rdata <= ram_q;
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= ram_q;
            a_ack   <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ram_wren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: self-checking bench for spram_arbiter with a behavioural
// single-port RAM and a transaction-level reference memory.
module tb_spram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0;
  logic          a_wr = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0;
  logic          b_wr = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ack;
  logic          b_ack;
  logic [DW-1:0] a_rdata;
  logic [DW-1:0] b_rdata;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic          busy;

  logic [DW-1:0] ram_mem   [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  spram_arbiter #(
    .address_width(AW),
    .data_width   (DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .a_req      (a_req),
    .a_wr       (a_wr),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_wr       (b_wr),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .ram_wren   (ram_wren),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_q      (ram_q),
    .busy       (busy)
  );

  // Single-port RAM: registered read, write-through on write.
  always @(posedge clock) begin
    if (ram_wren) begin
      ram_mem[ram_address] <= ram_data;
      ram_q                <= ram_data;
    end else begin
      ram_q <= ram_mem[ram_address];
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i]   = '0;
      model_mem[i] = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drop_requests();
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic apply_reset();
    drop_requests();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Issue one request, wait (bounded) for its ack, then release req.
  task automatic run_access(input bit on_b, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                            output int lat, output logic [AW-1:0] seen_addr,
                            output logic seen_wren, output bit other_ack);
    lat = 0; rdata = 'x; seen_addr = 'x; seen_wren = 1'bx; other_ack = 1'b0;
    if (on_b) begin
      b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata;
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 1) begin
        seen_addr = ram_address;
        seen_wren = ram_wren;
      end
      if (on_b ? a_ack : b_ack) other_ack = 1'b1;
      if (on_b ? b_ack : a_ack) begin
        lat   = i;
        rdata = on_b ? b_rdata : a_rdata;
        break;
      end
    end
    drop_requests();
    @(negedge clock);
  endtask

  // Both requesters issue at once; records the cycle of each ack.
  task automatic dual_access(input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                             output int a_cyc, output int b_cyc,
                             output logic [DW-1:0] a_rd, output logic [DW-1:0] b_rd);
    a_cyc = 0; b_cyc = 0; a_rd = 'x; b_rd = 'x;
    a_req = 1'b1; a_wr = 1'b0; a_addr = aa;
    b_req = 1'b1; b_wr = 1'b0; b_addr = ba;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (a_ack && a_cyc == 0) begin a_cyc = i; a_rd = a_rdata; a_req = 1'b0; end
      if (b_ack && b_cyc == 0) begin b_cyc = i; b_rd = b_rdata; b_req = 1'b0; end
      if (a_cyc != 0 && b_cyc != 0) break;
    end
    drop_requests();
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({busy, a_ack, b_ack, ram_wren} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, a_ack, b_ack, ram_wren});
    end
    vectors++;
    if (ram_address !== '0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h expected 000", ram_address);
    end
    vectors++;
    if (ram_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 00", ram_data);
    end
    vectors++;
    if ({a_rdata, b_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h expected 0000", {a_rdata, b_rdata});
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_a_write();
    a_req = 1'b1; a_wr = 1'b1; a_addr = 10'h005; a_wdata = 8'hA5;
    model_mem[10'h005] = 8'hA5;
    @(negedge clock);
    vectors++;
    if ({busy, ram_wren, ram_address, ram_data} !== {1'b1, 1'b1, 10'h005, 8'hA5}) begin
      miscompares++;
      $display("FAIL wr_addr_cycle: got busy=%b wren=%b addr=%h data=%h expected 1 1 005 a5",
               busy, ram_wren, ram_address, ram_data);
    end
    @(negedge clock);
    vectors++;
    if ({busy, ram_wren, a_ack} !== 3'b100) begin
      miscompares++;
      $display("FAIL wr_data_cycle: got busy/wren/ack=%b expected 100", {busy, ram_wren, a_ack});
    end
    @(negedge clock);
    vectors++;
    if ({a_ack, b_ack, busy, a_rdata} !== {3'b100, 8'hA5}) begin
      miscompares++;
      $display("FAIL wr_ack: got ack_a=%b ack_b=%b busy=%b rdata=%h expected 1 0 0 a5",
               a_ack, b_ack, busy, a_rdata);
    end
    drop_requests();
    @(negedge clock);
    vectors++;
    if (a_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_ack_pulse: got %b expected 0", a_ack);
    end
  endtask

  task automatic test_b_read();
    b_req = 1'b1; b_wr = 1'b0; b_addr = 10'h005; b_wdata = 8'h3C;
    @(negedge clock);
    vectors++;
    if ({ram_wren, ram_address} !== {1'b0, 10'h005}) begin
      miscompares++;
      $display("FAIL rd_addr_cycle: got wren=%b addr=%h expected 0 005", ram_wren, ram_address);
    end
    // Inputs wander mid-access; the access in flight must not notice.
    b_addr = 10'h123; b_wr = 1'b1; b_wdata = 8'h77;
    @(negedge clock);
    vectors++;
    if ({ram_wren, ram_address} !== {1'b0, 10'h005}) begin
      miscompares++;
      $display("FAIL rd_hold: got wren=%b addr=%h expected 0 005", ram_wren, ram_address);
    end
    @(negedge clock);
    vectors++;
    if ({b_ack, b_rdata} !== {1'b1, model_mem[10'h005]}) begin
      miscompares++;
      $display("FAIL rd_ack: got ack=%b rdata=%h expected 1 %h", b_ack, b_rdata, model_mem[10'h005]);
    end
    vectors++;
    if ({a_ack, a_rdata} !== {1'b0, 8'hA5}) begin
      miscompares++;
      $display("FAIL rd_other: got a_ack=%b a_rdata=%h expected 0 a5", a_ack, a_rdata);
    end
    drop_requests();
    @(negedge clock);
    vectors++;
    if (b_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_ack_pulse: got %b expected 0", b_ack);
    end
  endtask

  task automatic test_boundary();
    logic [DW-1:0] rd;
    logic [AW-1:0] sa;
    logic sw;
    int lat;
    bit oth;
    logic [AW-1:0] top;
    top = '1;
    run_access(1'b0, 1'b1, 10'h000, 8'h11, rd, lat, sa, sw, oth);
    model_mem[10'h000] = 8'h11;
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL bnd_lat: got %0d expected 3", lat);
    end
    run_access(1'b0, 1'b1, top, 8'hFF, rd, lat, sa, sw, oth);
    model_mem[top] = 8'hFF;
    vectors++;
    if ({sw, sa, rd} !== {1'b1, 10'h3FF, 8'hFF}) begin
      miscompares++;
      $display("FAIL bnd_write: got wren=%b addr=%h rdata=%h expected 1 3ff ff", sw, sa, rd);
    end
    run_access(1'b1, 1'b0, top, 8'h00, rd, lat, sa, sw, oth);
    vectors++;
    if ({sa, rd, oth} !== {10'h3FF, model_mem[top], 1'b0}) begin
      miscompares++;
      $display("FAIL bnd_readback: got addr=%h rdata=%h other_ack=%b expected 3ff %h 0",
               sa, rd, oth, model_mem[top]);
    end
    run_access(1'b1, 1'b0, 10'h000, 8'h00, rd, lat, sa, sw, oth);
    vectors++;
    if ({sa, rd} !== {10'h000, model_mem[10'h000]}) begin
      miscompares++;
      $display("FAIL bnd_alias: got addr=%h rdata=%h expected 000 %h", sa, rd, model_mem[10'h000]);
    end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0;
    int c0 = 0;
    int c1 = 0;
    logic [DW-1:0] r0 = 'x;
    logic [DW-1:0] r1 = 'x;
    bit oth = 1'b0;
    logic [DW-1:0] d1;
    d1 = DW'($urandom);
    a_req = 1'b1; a_wr = 1'b1; a_addr = 10'h010; a_wdata = d1;
    model_mem[10'h010] = d1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clock);
      if (b_ack) oth = 1'b1;
      if (a_ack) begin
        n_ack++;
        if (n_ack == 1) begin
          c0 = cyc; r0 = a_rdata;
          a_wr = 1'b0;
        end else if (n_ack == 2) begin
          c1 = cyc; r1 = a_rdata;
          a_req = 1'b0;
        end
      end
    end
    drop_requests();
    vectors++;
    if (n_ack !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d acks expected 2", n_ack);
    end
    vectors++;
    if (c0 !== 3 || c1 !== 7) begin
      miscompares++;
      $display("FAIL b2b_timing: got ack cycles %0d,%0d expected 3,7", c0, c1);
    end
    vectors++;
    if ({r0, r1, oth} !== {d1, d1, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_data: got %h,%h other_ack=%b expected %h,%h 0", r0, r1, oth, d1, d1);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    logic [AW-1:0] sa;
    logic sw;
    int lat;
    bit oth;
    // Reset while a read sits in DATA: abandoned, no ack.
    a_req = 1'b1; a_wr = 1'b0; a_addr = 10'h005;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drop_requests();
    @(negedge clock);
    vectors++;
    if ({a_ack, b_ack, busy, ram_wren, ram_address, ram_data, a_rdata, b_rdata} !== '0) begin
      miscompares++;
      $display("FAIL rst_data: got ack=%b%b busy=%b wren=%b addr=%h data=%h rd=%h/%h expected all 0",
               a_ack, b_ack, busy, ram_wren, ram_address, ram_data, a_rdata, b_rdata);
    end
    reset = 1'b0;
    run_access(1'b0, 1'b0, 10'h005, 8'h00, rd, lat, sa, sw, oth);
    vectors++;
    if (lat !== 3 || rd !== model_mem[10'h005]) begin
      miscompares++;
      $display("FAIL rst_reissue: got lat=%0d rdata=%h expected 3 %h", lat, rd, model_mem[10'h005]);
    end
    // Reset during the ADDR cycle of a write: the RAM write still lands.
    a_req = 1'b1; a_wr = 1'b1; a_addr = 10'h040; a_wdata = 8'h5A;
    @(negedge clock);
    reset = 1'b1;
    drop_requests();
    model_mem[10'h040] = 8'h5A;
    @(negedge clock);
    vectors++;
    if ({a_ack, busy, ram_wren} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_addr: got ack/busy/wren=%b expected 000", {a_ack, busy, ram_wren});
    end
    reset = 1'b0;
    run_access(1'b1, 1'b0, 10'h040, 8'h00, rd, lat, sa, sw, oth);
    vectors++;
    if (rd !== model_mem[10'h040]) begin
      miscompares++;
      $display("FAIL rst_write_lands: got %h expected %h", rd, model_mem[10'h040]);
    end
  endtask

  task automatic test_arbitration();
    int ac, bc, lat;
    logic [DW-1:0] ard, brd, rd;
    logic [AW-1:0] sa;
    logic sw;
    bit oth;
    bit exp_b_first;
    apply_reset();
    @(negedge clock);
    // After reset both builds grant A first on a tie.
    dual_access(10'h005, 10'h3FF, ac, bc, ard, brd);
    vectors++;
    if (ac !== 3 || bc !== 6) begin
      miscompares++;
      $display("FAIL arb_tie1: got a@%0d b@%0d expected a@3 b@6", ac, bc);
    end
    vectors++;
    if ({ard, brd} !== {model_mem[10'h005], model_mem[10'h3FF]}) begin
      miscompares++;
      $display("FAIL arb_data: got %h,%h expected %h,%h", ard, brd, model_mem[10'h005], model_mem[10'h3FF]);
    end
    // Make A the most recent grant, then tie again.
    run_access(1'b0, 1'b0, 10'h000, 8'h00, rd, lat, sa, sw, oth);
`ifdef SPRAM_ARBITER_ROUND_ROBIN_EN
    exp_b_first = 1'b1;
`else
    exp_b_first = 1'b0;
`endif
    dual_access(10'h000, 10'h005, ac, bc, ard, brd);
    vectors++;
    if ((exp_b_first && (bc !== 3 || ac !== 6)) || (!exp_b_first && (ac !== 3 || bc !== 6))) begin
      miscompares++;
      $display("FAIL arb_tie2: got a@%0d b@%0d expected %s first", ac, bc, exp_b_first ? "b" : "a");
    end
  endtask

  task automatic test_contention();
    int acks_seen = 0;
    int last_cyc = 0;
    int rem_a = 5;
    int rem_b = 5;
    bit exp_b = 1'b0;
    logic [DW-1:0] exp_rd;
    apply_reset();
    @(negedge clock);
    a_req = 1'b1; a_wr = 1'($urandom_range(0, 1)); a_addr = AW'($urandom_range(0, 7)); a_wdata = DW'($urandom);
    b_req = 1'b1; b_wr = 1'($urandom_range(0, 1)); b_addr = AW'($urandom_range(0, 7)); b_wdata = DW'($urandom);
    for (int cyc = 1; cyc <= 60 && acks_seen < 10; cyc++) begin
      @(negedge clock);
      if (a_ack || b_ack) begin
        // Serialised accesses: reference memory updated in ack order.
        if (exp_b) begin
          if (b_wr) begin model_mem[b_addr] = b_wdata; exp_rd = b_wdata; end
          else exp_rd = model_mem[b_addr];
        end else begin
          if (a_wr) begin model_mem[a_addr] = a_wdata; exp_rd = a_wdata; end
          else exp_rd = model_mem[a_addr];
        end
        vectors++;
        if ({a_ack, b_ack} !== (exp_b ? 2'b01 : 2'b10)) begin
          miscompares++;
          $display("FAIL cont_owner: ack %0d got a/b=%b%b expected %s", acks_seen, a_ack, b_ack, exp_b ? "b" : "a");
        end
        vectors++;
        if ((exp_b ? b_rdata : a_rdata) !== exp_rd) begin
          miscompares++;
          $display("FAIL cont_data: ack %0d got %h expected %h", acks_seen, exp_b ? b_rdata : a_rdata, exp_rd);
        end
        vectors++;
        if (cyc - last_cyc !== 3) begin
          miscompares++;
          $display("FAIL cont_spacing: ack %0d got %0d cycles expected 3", acks_seen, cyc - last_cyc);
        end
        last_cyc = cyc;
        acks_seen++;
        if (a_ack) begin
          rem_a--;
          if (rem_a > 0) begin
            a_wr = 1'($urandom_range(0, 1));
            a_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            a_wdata = DW'($urandom);
          end else a_req = 1'b0;
        end
        if (b_ack) begin
          rem_b--;
          if (rem_b > 0) begin
            b_wr = 1'($urandom_range(0, 1));
            b_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            b_wdata = DW'($urandom);
          end else b_req = 1'b0;
        end
        exp_b = !exp_b;
      end
    end
    drop_requests();
    vectors++;
    if (acks_seen !== 10) begin
      miscompares++;
      $display("FAIL cont_timeout: got %0d acks expected 10", acks_seen);
    end
    repeat (4) @(negedge clock);
    vectors++;
    if ({busy, a_ack, b_ack} !== 3'b000) begin
      miscompares++;
      $display("FAIL cont_drain: got busy/acks=%b expected 000", {busy, a_ack, b_ack});
    end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_b_read();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_arbitration();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
